// File: rtl/mem_responder_if.sv
// Request/response bus between a fetch/data port and the memory responder.
interface mem_responder_if #(
    parameter int unsigned XLEN = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [XLEN-1:0]   req_adr;
    logic              req_we;
    logic [XLEN/8-1:0] req_be;
    logic [XLEN-1:0]   req_wdata;
    logic              flush;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_data;
    logic              resp_err;

    // Requester side
    modport master (
        output req_valid, req_adr, req_we, req_be, req_wdata, flush,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    // Memory side
    modport slave (
        input  req_valid, req_adr, req_we, req_be, req_wdata, flush,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: serves word requests from an internal RAM with a
// fixed accept-to-response latency; flush kills responses still in flight.
// When INIT_FILE is set the RAM is not swept; its image is expected to be
// placed into mem by the harness and is kept across resets.
module mem_responder #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned NB        = XLEN / 8;
    localparam logic [XLEN:0] ADR_LIMIT = (XLEN+1)'(DEPTH * 4);
    localparam bit          ZERO_FILL = (INIT_FILE == "");

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state;
    logic [AW-1:0]     init_cnt;
    logic [XLEN-1:0]   mem [DEPTH];

    logic              run;
    logic              accept;
    logic              adr_err;
    logic [AW-1:0]     word_idx;

    logic [LATENCY-1:0] pipe_valid;
    logic [LATENCY-1:0] pipe_err;
    logic [XLEN-1:0]    pipe_data [LATENCY];

    // Request decode: acceptance, word index and access error
    assign run           = (state == ST_RUN);
    assign bus.req_ready = run & ~bus.flush & ~rst;
    assign accept        = bus.req_valid & bus.req_ready;
    assign word_idx      = bus.req_adr[AW+1:2];
    assign adr_err       = (bus.req_adr[1:0] != 2'b00) ||
                           ({1'b0, bus.req_adr} >= ADR_LIMIT);

    // Mode FSM: zero-fill sweep after reset (no image), then serve requests
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ZERO_FILL ? ST_INIT : ST_RUN;
            init_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + AW'(1);
                    if (init_cnt == AW'(DEPTH - 1)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_INIT;
            endcase
        end
    end

    // RAM write port: sweep zeros during INIT, byte-enabled writes in RUN
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= '0;
        end else if (accept && bus.req_we && !adr_err) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (bus.req_be[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 captures the accepted request, flush empties it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                pipe_data[i] <= '0;
            end
        end else if (run && bus.flush) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept & adr_err;
            pipe_data[0]  <= (accept && !bus.req_we && !adr_err) ? mem[word_idx] : '0;
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    // Responses come straight from the last pipeline stage
    assign bus.resp_valid = pipe_valid[LATENCY-1];
    assign bus.resp_err   = pipe_err[LATENCY-1];
    assign bus.resp_data  = pipe_data[LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: two instances (LATENCY 2 and 3, DEPTH 16)
// share one stimulus stream.
module tb_mem_responder;
    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_adr;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        flush;

    int n_checks;
    int n_fail;

    logic [31:0] tp_adr [8] = '{32'h0, 32'h8, 32'h3C, 32'h8, 32'h0, 32'h3C, 32'h8, 32'h8};
    logic [31:0] tp_exp [8] = '{32'h0, 32'hDE22BE44, 32'hCAFEF00D, 32'hDE22BE44,
                                32'h0, 32'hCAFEF00D, 32'hDE22BE44, 32'hDE22BE44};

    mem_responder_if #(.XLEN(32)) bus2 ();
    mem_responder_if #(.XLEN(32)) bus3 ();

    assign bus2.req_valid = req_valid;
    assign bus2.req_adr   = req_adr;
    assign bus2.req_we    = req_we;
    assign bus2.req_be    = req_be;
    assign bus2.req_wdata = req_wdata;
    assign bus2.flush     = flush;
    assign bus3.req_valid = req_valid;
    assign bus3.req_adr   = req_adr;
    assign bus3.req_we    = req_we;
    assign bus3.req_be    = req_be;
    assign bus3.req_wdata = req_wdata;
    assign bus3.flush     = flush;

    mem_responder #(.XLEN(32), .DEPTH(16), .LATENCY(2), .INIT_FILE("")) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    mem_responder #(.XLEN(32), .DEPTH(16), .LATENCY(3), .INIT_FILE("")) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request, inputs idle again after the edge
    task automatic drive(input logic we, input logic [31:0] adr, input logic [3:0] be,
                         input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_be    = be;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    initial begin
        logic late;
        logic busy;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_adr   = '0;
        req_we    = 1'b0;
        req_be    = '0;
        req_wdata = '0;
        flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready2", bus2.req_ready, 1'b0);
        check("rst_ready3", bus3.req_ready, 1'b0);
        check("rst_valid", bus2.resp_valid, 1'b0);
        check("rst_data", bus2.resp_data, 32'h0);
        check("rst_err", bus2.resp_err, 1'b0);

        // Init sweep: 16 cycles not ready, then ready
        rst = 1'b0;
        check("init_ready_first", bus2.req_ready, 1'b0);
        repeat (15) tick();
        check("init_ready_last", bus2.req_ready, 1'b0);
        tick();
        check("run_ready2", bus2.req_ready, 1'b1);
        check("run_ready3", bus3.req_ready, 1'b1);

        drive(1'b0, 32'h0, 4'h0, 32'h0);
        check("rd0_v_early", bus2.resp_valid, 1'b0);
        tick();
        check("rd0_v", bus2.resp_valid, 1'b1);
        check("rd0_d", bus2.resp_data, 32'h0);

        // Write then back-to-back read of the same word
        drive(1'b1, 32'h8, 4'hF, 32'hDEADBEEF);
        drive(1'b0, 32'h8, 4'h0, 32'h0);
        check("wr_resp_v", bus2.resp_valid, 1'b1);
        check("wr_resp_d", bus2.resp_data, 32'h0);
        check("wr_resp_e", bus2.resp_err, 1'b0);
        tick();
        check("rd8_v", bus2.resp_valid, 1'b1);
        check("rd8_d", bus2.resp_data, 32'hDEADBEEF);
        tick();
        check("idle_v", bus2.resp_valid, 1'b0);
        check("idle_d", bus2.resp_data, 32'h0);

        // Byte enables
        drive(1'b1, 32'h8, 4'b0101, 32'h11223344);
        drive(1'b0, 32'h8, 4'h0, 32'h0);
        tick();
        check("be_d", bus2.resp_data, 32'hDE22BE44);

        // Errors: misaligned read, out-of-range write, misaligned write
        drive(1'b0, 32'h6, 4'h0, 32'h0);
        tick();
        check("mis_v", bus2.resp_valid, 1'b1);
        check("mis_e", bus2.resp_err, 1'b1);
        check("mis_d", bus2.resp_data, 32'h0);
        drive(1'b1, 32'h40, 4'hF, 32'hFFFFFFFF);
        tick();
        check("oor_v", bus2.resp_valid, 1'b1);
        check("oor_e", bus2.resp_err, 1'b1);
        drive(1'b1, 32'hB, 4'hF, 32'h12345678);
        tick();
        check("miswr_e", bus2.resp_err, 1'b1);
        drive(1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        check("oor_ram_d", bus2.resp_data, 32'h0);
        check("oor_ram_e", bus2.resp_err, 1'b0);
        drive(1'b0, 32'h8, 4'h0, 32'h0);
        tick();
        check("miswr_ram_d", bus2.resp_data, 32'hDE22BE44);

        // Last in-range word
        drive(1'b1, 32'h3C, 4'hF, 32'hCAFEF00D);
        drive(1'b0, 32'h3C, 4'h0, 32'h0);
        tick();
        check("top_d", bus2.resp_data, 32'hCAFEF00D);
        check("top_e", bus2.resp_err, 1'b0);
        tick();

        // Flush: reads at T, T+1; flush with a request at T+2
        drive(1'b0, 32'h8, 4'h0, 32'h0);
        drive(1'b0, 32'h3C, 4'h0, 32'h0);
        check("fl_l2_pre_v", bus2.resp_valid, 1'b1);
        check("fl_l2_pre_d", bus2.resp_data, 32'hDE22BE44);
        req_valid = 1'b1;
        req_adr   = 32'h0;
        flush     = 1'b1;
        #1;
        check("fl_ready2", bus2.req_ready, 1'b0);
        check("fl_ready3", bus3.req_ready, 1'b0);
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        check("fl_l2_killed", bus2.resp_valid, 1'b0);
        check("fl_t3_v", bus3.resp_valid, 1'b0);
        req_valid = 1'b1;
        req_adr   = 32'h3C;
        #1;
        check("fl_post_ready", bus3.req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        check("fl_t4_v", bus3.resp_valid, 1'b0);
        tick();
        check("fl_t5_v", bus3.resp_valid, 1'b0);
        tick();
        check("fl_post_v", bus3.resp_valid, 1'b1);
        check("fl_post_d", bus3.resp_data, 32'hCAFEF00D);
        tick();

        // Eight back-to-back reads
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                req_valid = 1'b1;
                req_we    = 1'b0;
                req_adr   = tp_adr[i];
            end else begin
                req_valid = 1'b0;
            end
            if (i < 2) begin
                check("tp_empty", bus2.resp_valid, 1'b0);
            end else begin
                check("tp_v", bus2.resp_valid, 1'b1);
                check("tp_d", bus2.resp_data, tp_exp[i-2]);
            end
            tick();
        end
        req_valid = 1'b0;
        tick();

        // Reset after three accepted reads
        req_valid = 1'b1;
        req_adr   = 32'h8;
        repeat (3) tick();
        check("mid_pre_v", bus2.resp_valid, 1'b1);
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        check("mid_rst_v2", bus2.resp_valid, 1'b0);
        check("mid_rst_d2", bus2.resp_data, 32'h0);
        check("mid_rst_v3", bus3.resp_valid, 1'b0);
        repeat (2) tick();
        rst  = 1'b0;
        late = 1'b0;
        busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            late = late | bus2.resp_valid | bus3.resp_valid;
            busy = busy | bus2.req_ready;
            tick();
        end
        check("mid_no_late", late, 1'b0);
        check("mid_init_ready", busy, 1'b0);
        check("mid_run_ready", bus2.req_ready, 1'b1);
        drive(1'b0, 32'h8, 4'h0, 32'h0);
        tick();
        check("mid_rezero_v", bus2.resp_valid, 1'b1);
        check("mid_rezero_d", bus2.resp_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
